// File: rtl/brick_field_render_if.sv
// rtl/brick_field_render_if.sv - game-logic request/status bundle for the brick renderer
interface brick_field_render_if;
  logic       load_level;
  logic       hit_req;
  logic [2:0] hit_row;
  logic [4:0] hit_col;
  logic       hit_ack;
  logic       hit_was_alive;
  logic [7:0] bricks_left;
  logic       all_clear;

  // game logic side
  modport master (
    output load_level, hit_req, hit_row, hit_col,
    input  hit_ack, hit_was_alive, bricks_left, all_clear
  );

  // renderer side
  modport slave (
    input  load_level, hit_req, hit_row, hit_col,
    output hit_ack, hit_was_alive, bricks_left, all_clear
  );
endinterface

// File: rtl/brick_field_render.sv
// rtl/brick_field_render.sv - brick wall pixel colour stage with vblank-only bitmap updates
module brick_field_render #(
  parameter int          FIELD_Y0 = 64,
  parameter int          BRICK_W  = 32,
  parameter int          BRICK_H  = 16,
  parameter logic [11:0] BG_RGB   = 12'h112
) (
  input  logic                CLK,
  input  logic                reset,
  input  logic [11:0]         hcounter,
  input  logic [10:0]         vcounter,
  input  logic                visible,
  input  logic                iHS,
  input  logic                iVS,
  brick_field_render_if.slave game,
  output logic [3:0]          oR,
  output logic [3:0]          oG,
  output logic [3:0]          oB,
  output logic                oHS,
  output logic                oVS
);
  localparam int          NUM_COLS    = 20;
  localparam int          NUM_ROWS    = 8;
  localparam int          NUM_BRICKS  = NUM_COLS * NUM_ROWS;
  localparam int          FIELD_W     = NUM_COLS * BRICK_W;
  localparam int          FIELD_Y1    = FIELD_Y0 + NUM_ROWS * BRICK_H;
  localparam int          BW_LOG      = $clog2(BRICK_W);
  localparam int          BH_LOG      = $clog2(BRICK_H);
  localparam logic [10:0] VBLANK_LINE = 11'd480;
  localparam logic [7:0]  FULL_COUNT  = 8'(NUM_BRICKS);
  localparam logic [4:0]  LAST_COL    = 5'(NUM_COLS - 1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_VB    = 3'd1,
    APPLY_LOAD = 3'd2,
    APPLY_HIT  = 3'd3,
    ACK        = 3'd4
  } state_t;

  // row*20 + col built from shifts so no multiplier is needed
  function automatic logic [7:0] brick_index(input logic [2:0] r, input logic [4:0] c);
    return ({5'd0, r} << 4) + ({5'd0, r} << 2) + {3'd0, c};
  endfunction

  function automatic logic [11:0] row_colour(input logic [2:0] r);
    logic [11:0] c;
    case (r)
      3'd0:    c = 12'hF00;
      3'd1:    c = 12'hF80;
      3'd2:    c = 12'hFF0;
      3'd3:    c = 12'h0F0;
      3'd4:    c = 12'h0FF;
      3'd5:    c = 12'h00F;
      3'd6:    c = 12'h80F;
      default: c = 12'hF0F;
    endcase
    return c;
  endfunction

  // pipeline state
  logic [11:0] h_q;
  logic [10:0] v_q;
  logic [10:0] vrel;
  logic        in_field_d, mortar_d;
  logic [2:0]  row_d;
  logic [4:0]  col_d;
  logic        in_field_q, mortar_q, vis_q, hs_q, vs_q;
  logic [2:0]  row_q;
  logic [4:0]  col_q;
  logic [7:0]  pix_idx;
  logic [11:0] colour_d;

  // bitmap and update control
  logic [NUM_BRICKS-1:0] alive_q;
  logic [7:0]            bricks_left_q;
  logic                  all_clear_q;
  logic                  was_alive_q;
  logic                  load_pend_q;
  state_t                state_q, state_d;
  logic                  vblank;
  logic                  do_load, do_hit;
  logic                  hit_in_range;
  logic [7:0]            hit_idx;
  logic                  hit_alive;

  assign vblank = (vcounter >= VBLANK_LINE);

  // S2 classification of the pixel held in S1
  always_comb begin
    vrel       = v_q - 11'(FIELD_Y0);
    in_field_d = (h_q < 12'(FIELD_W)) && (v_q >= 11'(FIELD_Y0)) && (v_q < 11'(FIELD_Y1));
    mortar_d   = in_field_d &&
                 (((h_q & 12'(BRICK_W - 1)) == 12'd0) || ((vrel & 11'(BRICK_H - 1)) == 11'd0));
    row_d      = 3'(vrel >> BH_LOG);
    col_d      = 5'(h_q >> BW_LOG);
  end

  // S1 counter capture and S2 classification/sync registers
  always_ff @(posedge CLK) begin
    if (!reset) begin
      h_q        <= '0;
      v_q        <= '0;
      in_field_q <= 1'b0;
      mortar_q   <= 1'b0;
      row_q      <= '0;
      col_q      <= '0;
      vis_q      <= 1'b0;
      hs_q       <= 1'b0;
      vs_q       <= 1'b0;
    end else begin
      h_q        <= hcounter;
      v_q        <= vcounter;
      in_field_q <= in_field_d;
      mortar_q   <= mortar_d;
      row_q      <= row_d;
      col_q      <= col_d;
      vis_q      <= visible;
      hs_q       <= iHS;
      vs_q       <= iVS;
    end
  end

  // S3 colour priority: blank, mortar, live brick, background
  always_comb begin
    pix_idx  = in_field_q ? brick_index(row_q, col_q) : 8'd0;
    colour_d = BG_RGB;
    if (!vis_q || mortar_q) begin
      colour_d = 12'h000;
    end else if (in_field_q && alive_q[pix_idx]) begin
      colour_d = row_colour(row_q);
    end
  end

  // S3 output registers driving the DAC pins
  always_ff @(posedge CLK) begin
    if (!reset) begin
      oR  <= '0;
      oG  <= '0;
      oB  <= '0;
      oHS <= 1'b0;
      oVS <= 1'b0;
    end else begin
      oR  <= colour_d[11:8];
      oG  <= colour_d[7:4];
      oB  <= colour_d[3:0];
      oHS <= hs_q;
      oVS <= vs_q;
    end
  end

  // address decode for the requested hit; out-of-range columns never touch the bitmap
  always_comb begin
    hit_in_range = (game.hit_col <= LAST_COL);
    hit_idx      = hit_in_range ? brick_index(game.hit_row, game.hit_col) : 8'd0;
    hit_alive    = hit_in_range && alive_q[hit_idx];
  end

  // update FSM state register
  always_ff @(posedge CLK) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // update FSM next state: bitmap changes only ever start inside vblank
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (load_pend_q || game.hit_req) state_d = WAIT_VB;
      end
      WAIT_VB: begin
        if (vblank) state_d = load_pend_q ? APPLY_LOAD : APPLY_HIT;
      end
      APPLY_LOAD: begin
        if (game.hit_req) state_d = vblank ? APPLY_HIT : WAIT_VB;
        else              state_d = IDLE;
      end
      APPLY_HIT: state_d = ACK;
      ACK:       state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // update FSM outputs
  always_comb begin
    do_load      = 1'b0;
    do_hit       = 1'b0;
    game.hit_ack = 1'b0;
    case (state_q)
      APPLY_LOAD: do_load      = 1'b1;
      APPLY_HIT:  do_hit       = 1'b1;
      ACK:        game.hit_ack = 1'b1;
      default:    ;
    endcase
  end

  // bitmap, live count and pending-load bookkeeping
  always_ff @(posedge CLK) begin
    if (!reset) begin
      alive_q       <= '1;
      bricks_left_q <= FULL_COUNT;
      all_clear_q   <= 1'b0;
      was_alive_q   <= 1'b0;
      load_pend_q   <= 1'b0;
    end else begin
      all_clear_q <= (bricks_left_q == 8'd0);
      // a pulse coinciding with the load itself stays pending for another pass
      if (game.load_level) begin
        load_pend_q <= 1'b1;
      end else if (do_load) begin
        load_pend_q <= 1'b0;
      end
      if (do_load) begin
        alive_q       <= '1;
        bricks_left_q <= FULL_COUNT;
      end else if (do_hit) begin
        if (hit_alive) begin
          alive_q[hit_idx] <= 1'b0;
          bricks_left_q    <= bricks_left_q - 8'd1;
          was_alive_q      <= 1'b1;
        end else begin
          was_alive_q <= 1'b0;
        end
      end
    end
  end

  assign game.hit_was_alive = was_alive_q;
  assign game.bricks_left   = bricks_left_q;
  assign game.all_clear     = all_clear_q;
endmodule
